// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, with a one-word hold buffer
// so consecutive words stream with no idle cycle between them.
//
// Ports:
//   clk_i          : clock, rising edge
//   srst_i         : synchronous active-high reset
//   data_i         : parallel word, bit width-1 sent first
//   data_mod_i     : bit count, 0 means width; 1 and 2 are dropped
//   data_val_i     : word request, taken when busy_o is low
//   ser_data_o     : serial bit, forced low when not valid
//   ser_data_val_o : serial bit valid
//   busy_o         : hold buffer full, requests are not taken
module serializer #(
    parameter int width = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [width-1:0]         data_i,
    input  logic [$clog2(width)-1:0] data_mod_i,
    input  logic                     data_val_i,
    output logic                     ser_data_o,
    output logic                     ser_data_val_o,
    output logic                     busy_o
);

    localparam int MW = $clog2(width);
    localparam int CW = MW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SHIFT_HOLD
    } state_t;

    state_t         state, state_nx;
    logic [width-1:0] shreg, shreg_nx;
    logic [width-1:0] hold, hold_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [CW-1:0]  hold_n, hold_n_nx;

    logic           accept;
    logic           ignore;
    logic           take;
    logic           last;
    logic [CW-1:0]  n_in;

    // a zero count encodes a full word
    assign n_in   = (data_mod_i == '0) ? CW'(width) : {1'b0, data_mod_i};
    assign ignore = (data_mod_i == MW'(1)) || (data_mod_i == MW'(2));
    assign accept = data_val_i & ~busy_o;
    // dropped words are still consumed but never change state
    assign take   = accept & ~ignore;
    assign last   = (cnt == CW'(1));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            hold   <= '0;
            hold_n <= '0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            cnt    <= cnt_nx;
            hold   <= hold_nx;
            hold_n <= hold_n_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        cnt_nx    = cnt;
        hold_nx   = hold;
        hold_n_nx = hold_n;
        unique case (state)
            IDLE: begin
                if (take) begin
                    shreg_nx = data_i;
                    cnt_nx   = n_in;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    // new word goes straight to the shifter, no gap
                    if (take) begin
                        shreg_nx = data_i;
                        cnt_nx   = n_in;
                    end else begin
                        shreg_nx = '0;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end
                end else begin
                    shreg_nx = shreg << 1;
                    cnt_nx   = cnt - CW'(1);
                    if (take) begin
                        hold_nx   = data_i;
                        hold_n_nx = n_in;
                        state_nx  = SHIFT_HOLD;
                    end
                end
            end
            SHIFT_HOLD: begin
                if (last) begin
                    shreg_nx  = hold;
                    cnt_nx    = hold_n;
                    hold_nx   = '0;
                    hold_n_nx = '0;
                    state_nx  = SHIFT;
                end else begin
                    shreg_nx = shreg << 1;
                    cnt_nx   = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ser_data_val_o = (state != IDLE);
    assign ser_data_o     = shreg[width-1] & ser_data_val_o;
    assign busy_o         = (state == SHIFT_HOLD);

endmodule

// File: tb/tb_serializer.sv
// Directed testbench for serializer.
// Checks reset, single/partial words, hold buffer streaming and mid-word reset.
module tb_serializer;

    logic        clk;
    logic        srst;
    logic [15:0] data;
    logic [3:0]  data_mod;
    logic        data_val;
    logic        ser;
    logic        ser_val;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    serializer #(.width(16)) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .data_i         (data),
        .data_mod_i     (data_mod),
        .data_val_i     (data_val),
        .ser_data_o     (ser),
        .ser_data_val_o (ser_val),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        srst     = 1'b1;
        data_val = 1'b1;
        data     = 16'hFFFF;
        data_mod = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_checks++;
            if ({ser, ser_val, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_out cyc=%0d got=%b want=000",
                         i, {ser, ser_val, busy});
            end
        end
        srst = 1'b0;
        tick;
        data_val = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({ser_val, ser} !== 2'b11) begin
                n_fail++;
                $display("FAIL reset_first bit=%0d got=%b want=11",
                         i, {ser_val, ser});
            end
            tick;
        end
        n_checks++;
        if ({ser_val, ser} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_end got=%b want=00", {ser_val, ser});
        end
    endtask

    task automatic test_single;
        logic [15:0] got;
        got      = '0;
        data     = 16'hA5C3;
        data_mod = 4'd0;
        data_val = 1'b1;
        tick;
        data_val = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'hA5C3;
            n_checks++;
            if (ser_val !== 1'b1 || ser !== w[15-i]) begin
                n_fail++;
                $display("FAIL single bit=%0d got=%b%b want=1%b",
                         i, ser_val, ser, w[15-i]);
            end
            if (ser_val === 1'b1) got = {got[14:0], ser};
            tick;
        end
        n_checks++;
        if (ser_val !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end val got=%b want=0", ser_val);
        end
        n_checks++;
        if (got !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL single_deser got=%h want=a5c3", got);
        end
    endtask

    task automatic test_partial;
        logic [4:0] exp;
        exp      = 5'b11110;
        data     = 16'hF000;
        data_mod = 4'd5;
        data_val = 1'b1;
        tick;
        data_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ser_val !== 1'b1 || ser !== exp[4-i]) begin
                n_fail++;
                $display("FAIL partial bit=%0d got=%b%b want=1%b",
                         i, ser_val, ser, exp[4-i]);
            end
            tick;
        end
        n_checks++;
        if (ser_val !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_end val got=%b want=0", ser_val);
        end
        for (int m = 1; m <= 2; m++) begin
            data     = 16'hFFFF;
            data_mod = 4'(m);
            data_val = 1'b1;
            tick;
            data_val = 1'b0;
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if ({ser_val, ser, busy} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL drop mod=%0d cyc=%0d got=%b want=000",
                             m, c, {ser_val, ser, busy});
                end
                tick;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w[3];
        logic [47:0] bits;
        int          idx;
        int          acc_edge[3];
        bit          acc;
        logic        eb;
        w    = '{16'h0001, 16'h8000, 16'hFFFF};
        bits = {16'h0001, 16'h8000, 16'hFFFF};
        idx  = 0;
        acc_edge = '{0, 0, 0};
        data_mod = 4'd0;
        for (int e = 1; e <= 49; e++) begin
            data_val = (idx < 3);
            data     = (idx < 3) ? w[idx] : 16'h0;
            acc      = data_val && !busy;
            tick;
            if (acc) begin
                if (idx < 3) acc_edge[idx] = e;
                idx++;
            end
            eb = (e >= 2 && e <= 16) || (e >= 18 && e <= 32);
            n_checks++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL b2b_busy edge=%0d got=%b want=%b",
                         e, busy, eb);
            end
            n_checks++;
            if (e <= 48) begin
                if (ser_val !== 1'b1 || ser !== bits[48-e]) begin
                    n_fail++;
                    $display("FAIL b2b_bit edge=%0d got=%b%b want=1%b",
                             e, ser_val, ser, bits[48-e]);
                end
            end else if (ser_val !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_end val got=%b want=0", ser_val);
            end
        end
        data_val = 1'b0;
        n_checks++;
        if (idx != 3 || acc_edge[0] != 1 || acc_edge[1] != 2 ||
            acc_edge[2] != 18) begin
            n_fail++;
            $display("FAIL b2b_accept n=%0d edges=%0d,%0d,%0d want 3:1,2,18",
                     idx, acc_edge[0], acc_edge[1], acc_edge[2]);
        end
    endtask

    task automatic test_min_word;
        logic [15:0] w[4];
        logic [11:0] bits;
        int          idx;
        int          acc_edge[4];
        bit          acc;
        logic        eb;
        w    = '{16'hE000, 16'h2000, 16'hE000, 16'h2000};
        bits = 12'b111_001_111_001;
        idx  = 0;
        acc_edge = '{0, 0, 0, 0};
        data_mod = 4'd3;
        for (int e = 1; e <= 13; e++) begin
            data_val = (idx < 4);
            data     = (idx < 4) ? w[idx] : 16'h0;
            acc      = data_val && !busy;
            tick;
            if (acc) begin
                if (idx < 4) acc_edge[idx] = e;
                idx++;
            end
            eb = (e == 2 || e == 3 || e == 5 || e == 6 ||
                  e == 8 || e == 9);
            n_checks++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL min_busy edge=%0d got=%b want=%b",
                         e, busy, eb);
            end
            n_checks++;
            if (e <= 12) begin
                if (ser_val !== 1'b1 || ser !== bits[12-e]) begin
                    n_fail++;
                    $display("FAIL min_bit edge=%0d got=%b%b want=1%b",
                             e, ser_val, ser, bits[12-e]);
                end
            end else if (ser_val !== 1'b0) begin
                n_fail++;
                $display("FAIL min_end val got=%b want=0", ser_val);
            end
        end
        data_val = 1'b0;
        n_checks++;
        if (idx != 4 || acc_edge[0] != 1 || acc_edge[1] != 2 ||
            acc_edge[2] != 5 || acc_edge[3] != 8) begin
            n_fail++;
            $display("FAIL min_accept n=%0d edges=%0d,%0d,%0d,%0d",
                     idx, acc_edge[0], acc_edge[1], acc_edge[2],
                     acc_edge[3]);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] w[2];
        logic [15:0] first;
        logic [15:0] clean;
        int          idx;
        bit          acc;
        logic        eb;
        w     = '{16'h1234, 16'h5555};
        first = 16'h1234;
        clean = 16'h00FF;
        idx   = 0;
        data_mod = 4'd0;
        for (int e = 1; e <= 8; e++) begin
            data_val = (idx < 2);
            data     = (idx < 2) ? w[idx] : 16'h0;
            acc      = data_val && !busy;
            tick;
            if (acc) idx++;
            eb = (e >= 2);
            n_checks++;
            if (busy !== eb || ser_val !== 1'b1 ||
                ser !== first[16-e]) begin
                n_fail++;
                $display("FAIL mid_pre edge=%0d got=%b%b%b want=%b1%b",
                         e, busy, ser_val, ser, eb, first[16-e]);
            end
        end
        data_val = 1'b0;
        srst     = 1'b1;
        tick;
        srst = 1'b0;
        n_checks++;
        if ({ser_val, ser, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset got=%b want=000",
                     {ser_val, ser, busy});
        end
        for (int c = 0; c < 20; c++) begin
            tick;
            n_checks++;
            if ({ser_val, ser, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_held cyc=%0d got=%b want=000",
                         c, {ser_val, ser, busy});
            end
        end
        data     = 16'h00FF;
        data_val = 1'b1;
        tick;
        data_val = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (ser_val !== 1'b1 || ser !== clean[15-i]) begin
                n_fail++;
                $display("FAIL mid_clean bit=%0d got=%b%b want=1%b",
                         i, ser_val, ser, clean[15-i]);
            end
            tick;
        end
        n_checks++;
        if (ser_val !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_end val got=%b want=0", ser_val);
        end
    endtask

    initial begin
        srst     = 1'b1;
        data     = '0;
        data_mod = '0;
        data_val = 1'b0;
        test_reset;
        tick;
        test_single;
        tick;
        test_partial;
        tick;
        test_back_to_back;
        tick;
        test_min_word;
        tick;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
